i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (slave) for FPGA-side testing of the host I2C master and for exposing FPGA data
//  to external I2C controllers. Oversamples SCL/SDA on clk, decodes START/STOP/address/data,
//  ACKs its own 7-bit address, receives write bytes and transmits read bytes. Never stretches SCL.
// PARAMETERS
//  SLAVE_ADDR  7'h42  7-bit target address matched after START
//  SYNC_STAGES 2      input synchronizer depth for scl/sda (>=2)
// PORTS
//  clk       in     1  system clock; must be >= 16x SCL rate
//  rst       in     1  asynchronous reset, active-high
//  scl       in     1  I2C clock line (input only, no stretching)
//  sda       inout  1  I2C data line; open-drain: driven 0 or 'z' only
//  data_tx   in     8  byte to send on next read byte; sampled on tx_req
//  data_rx   out    8  last byte received in a write transfer
//  rx_valid  out    1  1-cycle pulse: data_rx updated
//  tx_req    out    1  1-cycle pulse: data_tx captured into shift register
//  busy      out    1  high from address match until STOP/repeated START
//  nack_rx   out    1  1-cycle pulse: master NACKed a read byte (end of read)
// BEHAVIOUR
//  Reset: sda released ('z'), data_rx=0, rx_valid=0, tx_req=0, busy=0, nack_rx=0, FSM=IDLE.
//  Inputs pass SYNC_STAGES flops (reset value 1); edges detected on synchronized values.
//  START = sda falls while scl high; STOP = sda rises while scl high; both valid in any state.
//  START (incl. repeated): FSM->ADDR, bit counter=0, sda released, busy=0.
//  STOP: FSM->IDLE, sda released, busy=0. Mid-byte STOP discards partial byte, no rx_valid.
//  Data sampled on scl rising edge; sda output changed only on scl falling edge.
//  States:
//   IDLE     : sda released; wait for START.
//   ADDR     : shift 8 bits MSB first (7 addr + R/W). After 8th rise: match->ADDR_ACK,
//              mismatch->IDLE (ignore bus until next START).
//   ADDR_ACK : on next scl fall drive sda=0; busy=1. If R/W=1 pulse tx_req, load data_tx.
//              At following scl fall: R/W=0->WRITE (release sda); R/W=1->READ (drive MSB).
//   WRITE    : shift 8 bits on scl rises; after 8th: data_rx<=byte, rx_valid pulse,
//              ->WR_ACK.
//   WR_ACK   : drive sda=0 from next scl fall to the fall after it; ->WRITE. Every byte ACKed.
//   READ     : sda driven from shift reg (0 -> drive low, 1 -> release), MSB first, next bit
//              placed on each scl fall; after 8th bit's fall release sda ->RD_ACK.
//   RD_ACK   : sample sda on scl rise. 0 (ACK): pulse tx_req, load data_tx, drive MSB at
//              next fall ->READ. 1 (NACK): pulse nack_rx ->IDLE (sda released, busy=0).
//  Bit counter 3 bits, wraps 7->0 at byte end. Pulses last exactly one clk.
//  Latency: rx_valid asserted <= SYNC_STAGES+2 clk after the 8th data scl rise.
//  START/STOP detection has priority over data sampling in the same clk.
//  Asynchronous rst mid-transfer: sda released immediately (combinational from rst).
// TESTING
//  1 Write 0x42+W, byte 0xA5, STOP -> addr ACK, data ACK, data_rx=0xA5, rx_valid x1,
//    busy 1 then 0 after STOP.
//  2 Write to 0x17 -> no ACK (sda high on 9th clock), no rx_valid, busy stays 0.
//  3 Read 0x42+R, data_tx=0x3C then 0xC3, master ACK then NACK -> bus bytes 0x3C,0xC3;
//    tx_req x2, nack_rx x1, sda released after.
//  4 Write 0x42+W, 0x11, repeated START, 0x42+R, 0x5A, NACK -> data_rx=0x11, read 0x5A,
//    no STOP between.
//  5 STOP after 4 data bits of write -> no rx_valid, FSM IDLE, next full write of 0x80
//    gives data_rx=0x80.
//  6 Assert rst during READ with sda driven low -> sda 'z' same cycle, all outputs reset
//    values.

Source files
------------

// File: rtl/i2c_slave_if.sv
// Host-side handshake bundle of the I2C target: byte
// exchange with the FPGA logic plus transfer status.
interface i2c_slave_if;
   logic [7:0] data_tx;
   logic [7:0] data_rx;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   logic       nack_rx;

   modport slave (
      input  data_tx,
      output data_rx,
      output rx_valid,
      output tx_req,
      output busy,
      output nack_rx
   );

   modport master (
      output data_tx,
      input  data_rx,
      input  rx_valid,
      input  tx_req,
      input  busy,
      input  nack_rx
   );
endinterface

// File: rtl/i2c_slave.sv
// Oversampling I2C target: decodes START/STOP, ACKs its own
// address, receives write bytes and shifts out read bytes.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl,
   inout  wire         sda,
   i2c_slave_if.slave  host
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE,
      WR_ACK,
      READ,
      RD_ACK
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_q;
   logic                   sda_q;
   logic                   scl_s;
   logic                   sda_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_q    <= scl_s;
         sda_q    <= sda_s;
      end
   end

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

   state_t     state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [7:0] shreg, shreg_n;
   logic [7:0] data_rx, data_rx_n;
   logic       sda_low, sda_low_n;
   logic       busy, busy_n;
   logic       ph, ph_n;
   logic       rw, rw_n;
   logic       rx_valid, rx_valid_n;
   logic       tx_req, tx_req_n;
   logic       nack_rx, nack_rx_n;
   logic [7:0] shift_in;

   assign shift_in = {shreg[6:0], sda_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         shreg    <= '0;
         data_rx  <= '0;
         sda_low  <= 1'b0;
         busy     <= 1'b0;
         ph       <= 1'b0;
         rw       <= 1'b0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         nack_rx  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shreg    <= shreg_n;
         data_rx  <= data_rx_n;
         sda_low  <= sda_low_n;
         busy     <= busy_n;
         ph       <= ph_n;
         rw       <= rw_n;
         rx_valid <= rx_valid_n;
         tx_req   <= tx_req_n;
         nack_rx  <= nack_rx_n;
      end
   end

   // ph marks the second half of a two-fall ACK window
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      shreg_n    = shreg;
      data_rx_n  = data_rx;
      sda_low_n  = sda_low;
      busy_n     = busy;
      ph_n       = ph;
      rw_n       = rw;
      rx_valid_n = 1'b0;
      tx_req_n   = 1'b0;
      nack_rx_n  = 1'b0;
      if (start_det) begin
         state_n   = ADDR;
         cnt_n     = '0;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
         ph_n      = 1'b0;
      end else if (stop_det) begin
         state_n   = IDLE;
         cnt_n     = '0;
         sda_low_n = 1'b0;
         busy_n    = 1'b0;
         ph_n      = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               sda_low_n = 1'b0;
            end
            ADDR: begin
               if (scl_rise) begin
                  shreg_n = shift_in;
                  cnt_n   = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (shift_in[7:1] == SLAVE_ADDR) begin
                        state_n = ADDR_ACK;
                        rw_n    = shift_in[0];
                        ph_n    = 1'b0;
                     end else begin
                        state_n = IDLE;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ph) begin
                     sda_low_n = 1'b1;
                     busy_n    = 1'b1;
                     ph_n      = 1'b1;
                     if (rw) begin
                        tx_req_n = 1'b1;
                        shreg_n  = host.data_tx;
                     end
                  end else begin
                     ph_n  = 1'b0;
                     cnt_n = '0;
                     if (rw) begin
                        state_n   = READ;
                        sda_low_n = ~shreg[7];
                     end else begin
                        state_n   = WRITE;
                        sda_low_n = 1'b0;
                     end
                  end
               end
            end
            WRITE: begin
               if (scl_rise) begin
                  shreg_n = shift_in;
                  cnt_n   = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     data_rx_n  = shift_in;
                     rx_valid_n = 1'b1;
                     state_n    = WR_ACK;
                     ph_n       = 1'b0;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  if (!ph) begin
                     sda_low_n = 1'b1;
                     ph_n      = 1'b1;
                  end else begin
                     sda_low_n = 1'b0;
                     ph_n      = 1'b0;
                     state_n   = WRITE;
                  end
               end
            end
            READ: begin
               if (scl_fall) begin
                  if (cnt == 3'd7) begin
                     cnt_n     = '0;
                     sda_low_n = 1'b0;
                     ph_n      = 1'b0;
                     state_n   = RD_ACK;
                  end else begin
                     cnt_n     = cnt + 3'd1;
                     shreg_n   = {shreg[6:0], 1'b0};
                     sda_low_n = ~shreg[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && !ph) begin
                  if (!sda_s) begin
                     tx_req_n = 1'b1;
                     shreg_n  = host.data_tx;
                     ph_n     = 1'b1;
                  end else begin
                     nack_rx_n = 1'b1;
                     busy_n    = 1'b0;
                     state_n   = IDLE;
                  end
               end else if (scl_fall && ph) begin
                  ph_n      = 1'b0;
                  cnt_n     = '0;
                  sda_low_n = ~shreg[7];
                  state_n   = READ;
               end
            end
            default: begin
               state_n   = IDLE;
               sda_low_n = 1'b0;
               busy_n    = 1'b0;
            end
         endcase
      end
   end

   // rst gates the pad so the line frees without waiting for clk
   assign sda = (sda_low && !rst) ? 1'b0 : 1'bz;

   assign host.data_rx  = data_rx;
   assign host.rx_valid = rx_valid;
   assign host.tx_req   = tx_req;
   assign host.busy     = busy;
   assign host.nack_rx  = nack_rx;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master
// with write-transfer vector table plus read/corner sequences.
module tb_i2c_slave;

   logic clk;
   logic rst;
   logic scl_m;
   logic m_low;
   wire  sda;

   i2c_slave_if hif ();

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_slave #(
      .SLAVE_ADDR  (7'h42),
      .SYNC_STAGES (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .scl  (scl_m),
      .sda  (sda),
      .host (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rx_cnt = 0;
   int tx_cnt = 0;
   int nack_cnt = 0;

   always @(posedge clk) begin
      if (hif.rx_valid) rx_cnt <= rx_cnt + 1;
      if (hif.tx_req)   tx_cnt <= tx_cnt + 1;
      if (hif.nack_rx)  nack_cnt <= nack_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic half();
      repeat (20) @(posedge clk);
   endtask

   task automatic start_c();
      m_low = 1'b0;
      repeat (4) @(posedge clk);
      scl_m = 1'b1;
      half();
      m_low = 1'b1;
      half();
      scl_m = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic stop_c();
      m_low = 1'b1;
      repeat (4) @(posedge clk);
      scl_m = 1'b1;
      half();
      m_low = 1'b0;
      half();
   endtask

   task automatic send_bit(input logic b);
      m_low = ~b;
      half();
      scl_m = 1'b1;
      half();
      scl_m = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic recv_bit(output logic b);
      m_low = 1'b0;
      half();
      scl_m = 1'b1;
      repeat (10) @(posedge clk);
      b = sda;
      repeat (10) @(posedge clk);
      scl_m = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(~ack);
   endtask

   typedef struct {
      logic [7:0] addr_rw;
      logic [7:0] data;
      logic       ack;
      int         nrx;
      logic [7:0] exp_rx;
   } wvec_t;

   wvec_t tbl [5];

   initial begin
      logic       a_ack;
      logic       d_ack;
      logic       bsy;
      logic [7:0] rd0;
      logic [7:0] rd1;
      int         rx0;
      int         tx0;
      int         nk0;

      tbl[0] = '{8'h84, 8'hA5, 1'b1, 1, 8'hA5};
      tbl[1] = '{8'h2E, 8'h3C, 1'b0, 0, 8'hA5};
      tbl[2] = '{8'h84, 8'h00, 1'b1, 1, 8'h00};
      tbl[3] = '{8'h84, 8'hFF, 1'b1, 1, 8'hFF};
      tbl[4] = '{8'h86, 8'h12, 1'b0, 0, 8'hFF};

      rst = 1'b1;
      scl_m = 1'b1;
      m_low = 1'b0;
      hif.data_tx = 8'h00;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_sda", 32'(sda), 32'd1);
      chk("reset_busy", 32'(hif.busy), 32'd0);
      chk("reset_data_rx", 32'(hif.data_rx), 32'd0);
      chk("reset_rx_valid", 32'(hif.rx_valid), 32'd0);

      for (int i = 0; i < 5; i++) begin
         rx0 = rx_cnt;
         start_c();
         send_byte(tbl[i].addr_rw, a_ack);
         @(negedge clk);
         bsy = hif.busy;
         send_byte(tbl[i].data, d_ack);
         stop_c();
         @(negedge clk);
         chk($sformatf("w%0d_addr_ack", i), 32'(a_ack), 32'(tbl[i].ack));
         chk($sformatf("w%0d_busy_mid", i), 32'(bsy), 32'(tbl[i].ack));
         chk($sformatf("w%0d_data_ack", i), 32'(d_ack), 32'(tbl[i].ack));
         chk($sformatf("w%0d_rx_cnt", i), 32'(rx_cnt - rx0), 32'(tbl[i].nrx));
         chk($sformatf("w%0d_data_rx", i), 32'(hif.data_rx), 32'(tbl[i].exp_rx));
         chk($sformatf("w%0d_busy_end", i), 32'(hif.busy), 32'd0);
      end

      tx0 = tx_cnt;
      nk0 = nack_cnt;
      hif.data_tx = 8'h3C;
      start_c();
      send_byte(8'h85, a_ack);
      hif.data_tx = 8'hC3;
      recv_byte(rd0, 1'b1);
      recv_byte(rd1, 1'b0);
      @(negedge clk);
      chk("rd_busy_after_nack", 32'(hif.busy), 32'd0);
      stop_c();
      @(negedge clk);
      chk("rd_addr_ack", 32'(a_ack), 32'd1);
      chk("rd_byte0", 32'(rd0), 32'h3C);
      chk("rd_byte1", 32'(rd1), 32'hC3);
      chk("rd_tx_req_cnt", 32'(tx_cnt - tx0), 32'd2);
      chk("rd_nack_cnt", 32'(nack_cnt - nk0), 32'd1);
      chk("rd_sda_released", 32'(sda), 32'd1);

      rx0 = rx_cnt;
      start_c();
      send_byte(8'h84, a_ack);
      send_byte(8'h11, d_ack);
      hif.data_tx = 8'h5A;
      start_c();
      send_byte(8'h85, bsy);
      recv_byte(rd0, 1'b0);
      stop_c();
      @(negedge clk);
      chk("rs_wr_ack", 32'({a_ack, d_ack}), 32'd3);
      chk("rs_rd_addr_ack", 32'(bsy), 32'd1);
      chk("rs_data_rx", 32'(hif.data_rx), 32'h11);
      chk("rs_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
      chk("rs_read", 32'(rd0), 32'h5A);

      rx0 = rx_cnt;
      start_c();
      send_byte(8'h84, a_ack);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      stop_c();
      @(negedge clk);
      chk("ps_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
      chk("ps_busy", 32'(hif.busy), 32'd0);
      chk("ps_data_rx", 32'(hif.data_rx), 32'h11);
      start_c();
      send_byte(8'h84, a_ack);
      send_byte(8'h80, d_ack);
      stop_c();
      @(negedge clk);
      chk("ps_next_ack", 32'({a_ack, d_ack}), 32'd3);
      chk("ps_next_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
      chk("ps_next_data_rx", 32'(hif.data_rx), 32'h80);

      hif.data_tx = 8'h00;
      start_c();
      send_byte(8'h85, a_ack);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rr_sda_driven", 32'(sda), 32'd0);
      rst = 1'b1;
      #1;
      chk("rr_sda_released", 32'(sda), 32'd1);
      chk("rr_busy", 32'(hif.busy), 32'd0);
      chk("rr_data_rx", 32'(hif.data_rx), 32'd0);
      chk("rr_pulses", 32'({hif.rx_valid, hif.tx_req, hif.nack_rx}), 32'd0);
      scl_m = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rr_idle_busy", 32'(hif.busy), 32'd0);
      chk("rr_idle_sda", 32'(sda), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
